// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential signed multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    // Width of the step counter for an n-bit operand (n >= 2).
    function automatic int count_width(input int n);
        if (n < 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/signed_to_magnitude.sv
// Splits an N-bit two's-complement value into sign and unsigned magnitude;
// the most-negative value maps to 2^(N-1), which still fits in N unsigned bits.
module signed_to_magnitude #(
    parameter int N = 5
) (
    input  logic signed [N-1:0] value,
    output logic        [N-1:0] mag,
    output logic                sign
);

    // Negate negative inputs; the unsigned result covers -2^(N-1) exactly.
    always_comb begin
        sign = value[N-1];
        if (sign) begin
            mag = ~value + N'(1);
        end else begin
            mag = value;
        end
    end

endmodule

// File: rtl/seq_signed_multiplier.sv
// Shift-add signed multiplier, one partial product per clock, valid/ready on both sides.
// Define MULT_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are zero.
module seq_signed_multiplier
    import mult_pkg::*;
#(
    parameter int N = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  a,
    input  logic signed [N-1:0]  b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*N-1:0]       p,
    output logic                 busy
);

    localparam int CW = count_width(N);
    localparam int PW = 2 * N;

    mult_state_t   state_r;
    mult_state_t   state_next_s;

    logic [N-1:0]  a_mag_s;
    logic [N-1:0]  b_mag_s;
    logic          a_sign_s;
    logic          b_sign_s;

    logic [N-1:0]  mcand_r;
    logic [N-1:0]  mplier_r;
    logic          sign_r;
    logic [PW-1:0] acc_r;
    logic [CW-1:0] count_r;
    logic [PW-1:0] p_r;

    logic [PW-1:0] addend_s;
    logic [PW-1:0] acc_next_s;
    logic [N-1:0]  mplier_next_s;
    logic [PW-1:0] p_next_s;
    logic          last_step_s;

    signed_to_magnitude #(.N(N)) u_a_mag (
        .value (a),
        .mag   (a_mag_s),
        .sign  (a_sign_s)
    );

    signed_to_magnitude #(.N(N)) u_b_mag (
        .value (b),
        .mag   (b_mag_s),
        .sign  (b_sign_s)
    );

    // One shift-add step and the signed result it would produce if it is the last.
    always_comb begin
        addend_s      = {{N{1'b0}}, mcand_r} << count_r;
        mplier_next_s = mplier_r >> 1;
        if (mplier_r[0]) begin
            acc_next_s = acc_r + addend_s;
        end else begin
            acc_next_s = acc_r;
        end
        // Negating zero yields zero, so a zero product never comes out negative.
        if (sign_r) begin
            p_next_s = ~acc_next_s + PW'(1);
        end else begin
            p_next_s = acc_next_s;
        end
`ifdef MULT_EARLY_EXIT_EN
        last_step_s = (count_r == CW'(N - 1)) || (mplier_next_s == {N{1'b0}});
`else
        last_step_s = (count_r == CW'(N - 1));
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_next_s = state_r;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next_s = BUSY;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (last_step_s) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Operand capture, accumulation and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {N{1'b0}};
            mplier_r <= {N{1'b0}};
            sign_r   <= 1'b0;
            acc_r    <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            p_r      <= {PW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r  <= a_mag_s;
                        mplier_r <= b_mag_s;
                        sign_r   <= a_sign_s ^ b_sign_s;
                        acc_r    <= {PW{1'b0}};
                        count_r  <= {CW{1'b0}};
                    end
                end
                BUSY: begin
                    acc_r    <= acc_next_s;
                    mplier_r <= mplier_next_s;
                    count_r  <= count_r + CW'(1);
                    if (last_step_s) begin
                        p_r <= p_next_s;
                    end
                end
                DONE: begin
                    p_r <= p_r;
                end
                default: begin
                    p_r <= p_r;
                end
            endcase
        end
    end

    assign p = p_r;

endmodule

// File: tb/tb_seq_signed_multiplier.sv
// Self-checking bench: N=5 instance for directed cases, N=8 instance for a random sweep,
// both compared every cycle against a latency/product model built from plain arithmetic.
module tb_seq_signed_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv   [2];
    logic        ordy [2];
    logic [7:0]  av   [2];
    logic [7:0]  bv   [2];
    logic        ir   [2];
    logic        ovl  [2];
    logic        bsy  [2];
    logic [9:0]  p5;
    logic [15:0] p8;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // Model state per instance.
    bit     m_busy [2];
    bit     m_ov   [2];
    longint m_p    [2];
    longint m_prod [2];
    int     m_el   [2];
    int     m_lat  [2];

    always #5 clk = ~clk;

    seq_signed_multiplier #(.N(5)) u_dut5 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(av[0][4:0]), .b(bv[0][4:0]), .out_valid(ovl[0]), .out_ready(ordy[0]),
        .p(p5), .busy(bsy[0])
    );

    seq_signed_multiplier #(.N(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(av[1]), .b(bv[1]), .out_valid(ovl[1]), .out_ready(ordy[1]),
        .p(p8), .busy(bsy[1])
    );

    function automatic int nw(input int id);
        return (id == 0) ? 5 : 8;
    endfunction

    function automatic longint sext(input int n, input logic [15:0] v);
        longint r;
        r = 0;
        for (int k = 0; k < n; k++) r[k] = v[k];
        if (v[n-1]) r = r - (longint'(1) << n);
        return r;
    endfunction

    function automatic longint dut_p(input int id);
        if (id == 0) return sext(10, {6'd0, p5});
        return sext(16, p8);
    endfunction

    // BUSY cycles the design needs for multiplier b.
    function automatic int lat_of(input int id, input logic [7:0] b);
`ifdef MULT_EARLY_EXIT_EN
        longint m;
        int     hb;
        m  = sext(nw(id), {8'd0, b});
        if (m < 0) m = -m;
        hb = 0;
        for (int k = 0; k < 16; k++) if (m[k]) hb = k + 1;
        return (hb < 1) ? 1 : hb;
`else
        return nw(id);
`endif
    endfunction

    task automatic chk(input string nm, input int id, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=%0d expected=%0d", nm, id, $time, act, exp);
        end
    endtask

    // Behavioural model: accept in idle, produce a*b after the operand-dependent latency.
    for (genvar g = 0; g < 2; g++) begin : g_model
        always @(posedge clk) begin
            if (rst) begin
                m_busy[g] <= 1'b0;
                m_ov[g]   <= 1'b0;
                m_p[g]    <= 0;
                m_el[g]   <= 0;
            end else if (m_ov[g]) begin
                if (ordy[g]) m_ov[g] <= 1'b0;
            end else if (m_busy[g]) begin
                if (m_el[g] + 1 == m_lat[g]) begin
                    m_busy[g] <= 1'b0;
                    m_ov[g]   <= 1'b1;
                    m_p[g]    <= m_prod[g];
                end else begin
                    m_el[g] <= m_el[g] + 1;
                end
            end else if (iv[g]) begin
                m_busy[g] <= 1'b1;
                m_el[g]   <= 0;
                m_lat[g]  <= lat_of(g, bv[g]);
                m_prod[g] <= sext(nw(g), {8'd0, av[g]}) * sext(nw(g), {8'd0, bv[g]});
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                chk("in_ready",  i, longint'(ir[i]),  longint'(!m_busy[i] && !m_ov[i]));
                chk("busy",      i, longint'(bsy[i]), longint'(m_busy[i]));
                chk("out_valid", i, longint'(ovl[i]), longint'(m_ov[i]));
                chk("p",         i, dut_p(i),         m_p[i]);
            end
        end
    end

    task automatic start(input int id, input logic [7:0] a, input logic [7:0] b);
        int g;
        g = 0;
        while ((m_busy[id] || m_ov[id]) && g < 200) begin
            @(posedge clk); #1; g++;
        end
        if (g >= 200) chk("ready_timeout", id, 0, 1);
        av[id] = a;
        bv[id] = b;
        iv[id] = 1'b1;
        @(posedge clk); #1;
        iv[id] = 1'b0;
    endtask

    task automatic finish_op(input int id, input int bp, input bit use_lit,
                             input longint lit, input int lat_exp);
        int cyc;
        cyc = 0;
        while (!ovl[id] && cyc < 64) begin
            iv[id] = 1'($urandom_range(0, 1));
            av[id] = 8'($urandom);
            bv[id] = 8'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        if (!ovl[id]) chk("done_timeout", id, 0, 1);
        if (use_lit) begin
            chk("p_literal", id, dut_p(id), lit);
            if (lat_exp > 0) chk("latency", id, cyc, lat_exp);
        end
        for (int k = 0; k < bp; k++) begin
            iv[id] = 1'($urandom_range(0, 1));
            av[id] = 8'($urandom);
            bv[id] = 8'($urandom);
            @(posedge clk); #1;
            if (use_lit) chk("p_held", id, dut_p(id), lit);
        end
        iv[id]   = 1'b0;
        ordy[id] = 1'b1;
        @(posedge clk); #1;
        ordy[id] = 1'b0;
        if (use_lit) begin
            chk("p_retained",    id, dut_p(id), lit);
            chk("in_ready_back", id, longint'(ir[id]), 1);
        end
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        longint     prod;
        int         lat_fixed;
        int         lat_early;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{8'(-10),  8'(4),  -40, 5, 3};
        vecs[1] = '{8'(11),   8'(-3), -33, 5, 2};
        vecs[2] = '{8'(-10),  8'(-11), 110, 5, 4};
        vecs[3] = '{8'(-16),  8'(-16), 256, 5, 5};
        vecs[4] = '{8'(-16),  8'(15), -240, 5, 4};
        vecs[5] = '{8'(0),    8'(-7),    0, 5, 3};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            iv[i] = 1'b0; ordy[i] = 1'b0; av[i] = 8'd0; bv[i] = 8'd0;
        end
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("reset_in_ready",  i, longint'(ir[i]),  1);
            chk("reset_out_valid", i, longint'(ovl[i]), 0);
            chk("reset_busy",      i, longint'(bsy[i]), 0);
            chk("reset_p",         i, dut_p(i),         0);
        end

        // Directed N=5 cases; the first one is held under backpressure for 10 cycles.
        for (int v = 0; v < 6; v++) begin
            start(0, vecs[v].a, vecs[v].b);
`ifdef MULT_EARLY_EXIT_EN
            finish_op(0, (v == 0) ? 10 : 0, 1'b1, vecs[v].prod, vecs[v].lat_early);
`else
            finish_op(0, (v == 0) ? 10 : 0, 1'b1, vecs[v].prod, vecs[v].lat_fixed);
`endif
        end

        // Reset two cycles into BUSY abandons the operation.
        start(0, 8'(-10), 8'(7));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_in_ready",  0, longint'(ir[0]),  1);
        chk("rst_out_valid", 0, longint'(ovl[0]), 0);
        chk("rst_p",         0, dut_p(0),         0);
        repeat (8) begin
            @(posedge clk); #1;
        end
        chk("rst_no_pulse", 0, longint'(ovl[0]), 0);
        start(0, 8'(3), 8'(5));
`ifdef MULT_EARLY_EXIT_EN
        finish_op(0, 0, 1'b1, 15, 3);
`else
        finish_op(0, 0, 1'b1, 15, 5);
`endif

        // N=8 latency corners.
        start(1, 8'(7), 8'(1));
`ifdef MULT_EARLY_EXIT_EN
        finish_op(1, 0, 1'b1, 7, 1);
`else
        finish_op(1, 0, 1'b1, 7, 8);
`endif
        start(1, 8'(-3), 8'(-128));
        finish_op(1, 0, 1'b1, 384, 8);
        start(1, 8'(-128), 8'(-128));
        finish_op(1, 1, 1'b1, 16384, 8);

        // Random N=8 sweep checked by the per-cycle model.
        for (int n = 0; n < 1000; n++) begin
            start(1, 8'($urandom), 8'($urandom));
            finish_op(1, $urandom_range(0, 3), 1'b0, 0, 0);
        end

        repeat (3) begin
            @(posedge clk); #1;
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
